// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial N-bit adder. One operand pair is accepted, then added one
// full-adder bit per cycle, LSB first. The carry lives in a 1-bit register
// between cycles. The finished result is held until the consumer takes it.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. in_rdy is high only in IDLE, and out_val is high
// only in DONE. Neither ready depends combinationally on the other side's
// valid. While out_val is high, sum/cout (and ovf) do not change.
//
// Timing: the accept edge loads the operands. N CALC edges follow. out_val
// rises after the Nth CALC edge. The minimum spacing between accepts is N+2
// cycles: IDLE, N x CALC, DONE.
//
// Parameters:
//   N        operand width, legal range 2..32 (default 8)
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; wins over every handshake
//   in_val   in   operand request valid
//   in_rdy   out  block can accept a request (IDLE)
//   in0,in1  in   N-bit addends
//   cin      in   carry-in
//   out_val  out  result valid (DONE)
//   out_rdy  in   consumer accepts the result
//   sum      out  N-bit result, (in0 + in1 + cin) mod 2^N
//   cout     out  carry out of bit N-1
//   ovf      out  (only with SERIAL_ADDER_OVERFLOW_EN) two's-complement
//                 overflow = carry into bit N-1 XOR cout
//
// Build option:
//   SERIAL_ADDER_OVERFLOW_EN  adds the ovf port and the register that
//                             captures the carry into the MSB.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_val,
    output logic         in_rdy,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic         cin,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    // The counter only has to reach N-1, the index of the last CALC edge.
    // N >= 2, so CW is at least 1.
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [N-1:0]  r_a;        // addend shift registers, consumed LSB first
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_res;      // result fills from the MSB end
    logic          r_c;        // running carry
    logic [CW-1:0] r_cnt;      // CALC edge index

    logic          w_sum_bit;
    logic          w_carry;
    logic          w_last;

    assign w_sum_bit = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last    = (r_cnt == LAST);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath. The operands are only sampled on the accept edge, so later
    // changes on in0/in1/cin cannot reach the result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_val) begin
                        r_a   <= in0;
                        r_b   <= in1;
                        r_res <= '0;
                        r_c   <= cin;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= {w_sum_bit, r_res[N-1:1]};
                    r_c   <= w_carry;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                    // DONE: hold everything steady for the consumer.
                end
            endcase
        end
    end

    assign sum  = r_res;
    // After the last CALC edge, the carry register holds bit N of the full sum.
    assign cout = r_c;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    // On the last CALC edge, r_c is still the carry into bit N-1.
    // Keep a copy of it so it can be compared with the final carry.
    logic r_c_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_msb <= 1'b0;
        end else if (r_state == IDLE && in_val) begin
            r_c_msb <= 1'b0;
        end else if (r_state == CALC && w_last) begin
            r_c_msb <= r_c;
        end
    end

    assign ovf = r_c_msb ^ r_c;
`endif

endmodule
